noc_inject_arbiter: RTL and testbench
=====================================

// Module: noc_inject_arbiter
// PURPOSE
// Shares one NoC router injection port among NUM_REQ local requesters (e.g. several shim_in
// serializers on one mesh node). Packet-level round-robin: a grant holds from head flit until
// tail flit, so packets never interleave. Tracks router input-buffer credits; never overruns it.
// PARAMETERS
// NUM_REQ            4    number of requesters, >=2
// FLIT_WIDTH         128  flit data width
// DEST_WIDTH         6    destination field width ({tid,tdest})
// FLIT_BUFFER_DEPTH  4    router input buffer depth = initial credit count, >=1
// PORTS
// clk          in   1                   NoC clock
// rst          in   1                   async reset, active-high
// req_valid    in   1 [NUM_REQ]         requester flit valid
// req_ready    out  1 [NUM_REQ]         flit accepted when valid&ready
// req_data     in   FLIT_WIDTH [NUM_REQ]
// req_dest     in   DEST_WIDTH [NUM_REQ]
// req_is_tail  in   1 [NUM_REQ]         last flit of packet
// data_out     out  FLIT_WIDTH          to router data_in
// dest_out     out  DEST_WIDTH          to router dest_in
// is_tail_out  out  1                   to router is_tail_in
// send_out     out  1                   to router send_in, one flit per cycle high
// credit_in    in   1                   from router credit_out, one buffer slot freed
// BEHAVIOUR
// - One clock (clk); reset asynchronous, active-high (rst). Reset: send_out=0, data_out/dest_out/
//   is_tail_out=0, req_ready=0, credits=FLIT_BUFFER_DEPTH, state=IDLE, rr_ptr=0.
// - Credit counter width $clog2(FLIT_BUFFER_DEPTH+1). Accept -> -1; credit_in -> +1; both in
//   same cycle -> unchanged. credit_in at full count: saturate, flag with simulation assertion.
// - No acceptance while credits==0; all req_ready low.
// - IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1.. mod NUM_REQ
//   (combinational). req_ready[winner]=1 iff credits>0; all others 0.
// - LOCKED(owner): req_ready[owner]=1 iff credits>0; others 0. Owner dropping valid mid-packet
//   keeps lock (others starve until its tail).
// - On accept of flit from i: next cycle send_out=1 with that flit's data/dest/is_tail (latency
//   1, registered outputs); send_out=0 in any cycle following no accept.
//   Non-tail -> LOCKED(owner=i). Tail -> IDLE, rr_ptr=(i+1) mod NUM_REQ.
// - Single-flit packet (head is tail): accepted in IDLE, stays IDLE, rr_ptr advances.
// - Back-to-back: tail accept and next packet's head from another requester may occur in
//   consecutive cycles; throughput 1 flit/cycle while credits allow.
// - Reset mid-packet: partial packet abandoned, state as above; router shares this reset.
// CONFIGURATION
// - NOC_INJECT_ARB_STATS_EN defined: adds output pkt_count 32 [NUM_REQ]; pkt_count[i]
//   increments on each accepted tail flit from i, wraps 2^32-1 -> 0, reset 0.
//   Undefined: port and counters absent; all other behaviour identical.
// TESTING
// - Reset release, no valids -> send_out=0, all req_ready=0 after credits present too; credits=4.
// - Req0 3-flit pkt, req1 2-flit pkt, both valid from cycle 0 -> 0,0,0,1,1 on send_out, no
//   interleave; rr_ptr=2 at end.
// - All 4 requesters send 1-flit pkts continuously, credit_in looped 2 cycles later -> order
//   0,1,2,3,0..; no requester gets 2 grants before others get 1.
// - credit_in held 0, req0 6-flit pkt -> exactly 4 send_out pulses, req_ready[0]=0; one
//   credit_in pulse -> 5th flit sent next cycle.
// - Accept and credit_in same cycle at credits=1 -> credits stays 1, next flit accepted.
// - Reset asserted after flit 2 of 4-flit pkt from req2 -> send_out=0 immediately, credits=4,
//   after release req1 granted first when req1,req2 valid (rr_ptr=0 scan).

Source files
------------

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-level round-robin injection arbiter with router credit tracking
// Optional per-requester tail counters under NOC_INJECT_ARB_STATS_EN.
module noc_inject_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]    req_dest,
  input  logic [NUM_REQ-1:0]                    req_is_tail,
  output logic [FLIT_WIDTH-1:0]                 data_out,
  output logic [DEST_WIDTH-1:0]                 dest_out,
  output logic                                  is_tail_out,
  output logic                                  send_out,
  input  logic                                  credit_in
`ifdef NOC_INJECT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]              pkt_count
`endif
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CW-1:0]   CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [IDXW:0]   NUM_REQ_W  = (IDXW + 1)'(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] owner, owner_next;
  logic [IDXW-1:0] rr_ptr, rr_ptr_next;
  logic [CW-1:0]   credits, credits_next;
  logic [IDXW-1:0] winner, sel, cand;
  logic [IDXW:0]   cand_sum;
  logic            win_found, accept;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDXW + 1)'(k);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      cand = cand_sum[IDXW-1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    req_ready   = '0;
    sel         = (state == LOCKED) ? owner : winner;
    if (!rst && (credits != '0) && (state == LOCKED || win_found)) req_ready[sel] = 1'b1;
    accept = req_valid[sel] & req_ready[sel];
    if (accept) begin
      if (req_is_tail[sel]) begin
        state_next  = IDLE;
        rr_ptr_next = (sel == LAST_IDX) ? '0 : sel + 1'b1;
      end else begin
        state_next = LOCKED;
        owner_next = sel;
      end
    end
    case ({accept, credit_in})
      2'b10:   credits_next = credits - 1'b1;
      2'b01:   credits_next = (credits == CREDIT_MAX) ? credits : credits + 1'b1;
      default: credits_next = credits;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      credits     <= CREDIT_MAX;
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      rr_ptr      <= rr_ptr_next;
      credits     <= credits_next;
      send_out    <= accept;
      if (accept) begin
        data_out    <= req_data[sel];
        dest_out    <= req_dest[sel];
        is_tail_out <= req_is_tail[sel];
      end
    end
  end

`ifdef NOC_INJECT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (accept && req_is_tail[sel]) begin
      pkt_count[sel] <= pkt_count[sel] + 32'd1;
    end
  end
`endif

  // A credit returned while already full means the router and arbiter disagree on buffer state.
  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(credit_in && !accept && credits == CREDIT_MAX));

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;
  localparam int N = 4, FW = 128, DW = 6, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid = '0, req_ready, req_is_tail = '0;
  logic [N-1:0][FW-1:0]  req_data = '0;
  logic [N-1:0][DW-1:0]  req_dest = '0;
  logic [FW-1:0]         data_out;
  logic [DW-1:0]         dest_out;
  logic                  is_tail_out, send_out;
  logic                  credit_in = 1'b0;
`ifdef NOC_INJECT_ARB_STATS_EN
  logic [N-1:0][31:0]    pkt_count;
`endif

  noc_inject_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_dest(req_dest), .req_is_tail(req_is_tail), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in)
`ifdef NOC_INJECT_ARB_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tag_data(input int row);
    for (int i = 0; i < N; i++) begin
      req_data[i] = {96'(i), 32'(row)};
      req_dest[i] = DW'(i + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_is_tail = '0;
    credit_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Spec-level reference: lock owner (-1 = none), round-robin start, credit count, pending flit.
  int             m_owner, m_rr, m_cred;
  logic           m_send;
  logic [FW-1:0]  m_data;
  logic [DW-1:0]  m_dest;
  logic           m_tail;

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
    logic [N-1:0] r;
    bit found;
    r = '0;
    found = 0;
    if (m_cred == 0) return r;
    if (m_owner >= 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (!found && v[(m_rr + k) % N]) begin
        r[(m_rr + k) % N] = 1'b1;
        found = 1;
      end
    end
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] acc;
    acc = req_valid & model_ready(req_valid);
    m_send = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_send = 1'b1;
        m_data = req_data[i];
        m_dest = req_dest[i];
        m_tail = req_is_tail[i];
        if (req_is_tail[i]) begin
          m_owner = -1;
          m_rr = (i + 1) % N;
        end else begin
          m_owner = i;
        end
        m_cred--;
      end
    end
    if (credit_in) m_cred++;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] tail;
    logic         credit;
    logic [N-1:0] ready;
    logic         send;
    int           src;
    logic         etail;
  } vec_t;

  vec_t tbl[12];
  int sends, accepted, got;
  int order[$];
  int due[$];
  logic [39:0] sent_hist;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 0, 1'b0};
    tbl[2]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
    tbl[3]  = '{4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
    tbl[4]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 0, 1'b1};
    tbl[5]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    tbl[6]  = '{4'b0111, 4'b0111, 1'b0, 4'b0100, 1'b1, 1, 1'b1};
    tbl[7]  = '{4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 2, 1'b1};
    tbl[8]  = '{4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b0, 0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 0, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0};

    // Reset state
    rst = 1'b1;
    tick();
    check("rst_send", FW'(send_out), '0);
    check("rst_data", data_out, '0);
    check("rst_ready", FW'(req_ready), '0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", FW'(req_ready), '0);
    check("post_rst_send", FW'(send_out), '0);

    // Two packets 3+2 flits, credit loop, rr_ptr=2 then credit exhaustion
    tick();
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].valid;
      req_is_tail = tbl[r].tail;
      credit_in = tbl[r].credit;
      tag_data(r);
      #1;
      check($sformatf("tbl%0d_ready", r), FW'(req_ready), FW'(tbl[r].ready));
      check($sformatf("tbl%0d_send", r), FW'(send_out), FW'(tbl[r].send));
      if (tbl[r].send) begin
        check($sformatf("tbl%0d_data", r), data_out, {96'(tbl[r].src), 32'(r - 1)});
        check($sformatf("tbl%0d_dest", r), FW'(dest_out), FW'(tbl[r].src + 1));
        check($sformatf("tbl%0d_tail", r), FW'(is_tail_out), FW'(tbl[r].etail));
      end
      tick();
    end

    // Four requesters, single-flit packets, credits looped back two cycles after send
    do_reset();
    tag_data(0);
    req_valid = '1;
    req_is_tail = '1;
    sent_hist = '0;
    order.delete();
    for (int t = 0; t < 40; t++) begin
      credit_in = (t >= 2) ? sent_hist[t-2] : 1'b0;
      #1;
      sent_hist[t] = send_out;
      if (send_out && order.size() < 16) order.push_back(int'(data_out[FW-1:32]));
      tick();
    end
    req_valid = '0;
    check("rr_count", FW'(order.size()), FW'(16));
    for (int k = 0; k < order.size(); k++) check($sformatf("rr_order%0d", k), FW'(order[k]), FW'(k % N));

    // Credit starvation: 6-flit packet, no credits returned
    do_reset();
    tag_data(0);
    sends = 0;
    accepted = 0;
    for (int t = 0; t < 10; t++) begin
      req_valid = 4'b0001;
      req_is_tail = (accepted == 5) ? 4'b0001 : 4'b0000;
      #1;
      if (req_valid[0] && req_ready[0]) accepted++;
      if (send_out) sends++;
      tick();
    end
    check("starve_sends", FW'(sends), FW'(4));
    check("starve_ready", FW'(req_ready), '0);
    credit_in = 1'b1;
    #1;
    check("starve_ready_pre_credit", FW'(req_ready), '0);
    tick();
    credit_in = 1'b0;
    #1;
    check("starve_ready_credit", FW'(req_ready), FW'(4'b0001));
    tick();
    check("starve_5th_send", FW'(send_out), FW'(1));
    tick();
    check("starve_after_send", FW'(send_out), FW'(0));
    req_valid = '0;

    // Reset mid-packet from requester 2
    do_reset();
    tag_data(0);
    accepted = 0;
    got = 0;
    for (int t = 0; t < 10 && accepted < 2; t++) begin
      req_valid = 4'b0100;
      req_is_tail = '0;
      #1;
      if (req_ready[2]) accepted++;
      tick();
    end
    check("mid_send_before_rst", FW'(send_out), FW'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_send", FW'(send_out), '0);
    check("mid_rst_ready", FW'(req_ready), '0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0110;
    req_is_tail = 4'b0110;
    #1;
    check("mid_first_grant", FW'(req_ready), FW'(4'b0010));
    req_valid = 4'b0010;
    sends = 0;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (send_out) sends++;
      tick();
    end
    check("mid_credits_full", FW'(sends), FW'(DEPTH));

    // Randomized traffic with random credit return delay against the reference model
    do_reset();
    m_owner = -1;
    m_rr = 0;
    m_cred = DEPTH;
    m_send = 1'b0;
    m_data = '0;
    m_dest = '0;
    m_tail = 1'b0;
    due.delete();
    got = 0;
    for (int t = 0; t < 3000; t++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_is_tail[i] = ($urandom_range(0, 2) == 0);
        req_data[i] = {$urandom, $urandom, $urandom, $urandom};
        req_dest[i] = DW'($urandom);
      end
      credit_in = 1'b0;
      if (due.size() > 0 && due[0] <= t) begin
        credit_in = 1'b1;
        void'(due.pop_front());
      end
      #1;
      if (req_ready !== model_ready(req_valid) || send_out !== m_send ||
          (m_send && (data_out !== m_data || dest_out !== m_dest || is_tail_out !== m_tail))) begin
        if (got < 5)
          $display("FAIL rnd_cycle%0d: got ready=%b send=%b dest=%0h tail=%b expected ready=%b send=%b dest=%0h tail=%b",
                   t, req_ready, send_out, dest_out, is_tail_out, model_ready(req_valid), m_send, m_dest, m_tail);
        got++;
        n_bad++;
      end
      n_cmp++;
      if (send_out) due.push_back((due.size() > 0 && due[$] > t) ? due[$] + 1 : t + int'($urandom_range(1, 5)));
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
